count_ctrl: RTL

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl_pkg.sv | 15 +
 rtl/rate_divider.sv | 31 +++
 rtl/count_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types and default widths for the count_ctrl slice.
// State encoding is visible on the count_ctrl state port, so it must stay fixed.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int CNT_W_DEFAULT = 8;
    localparam int DIV_W_DEFAULT = 26;

endpackage

// File: rtl/rate_divider.sv
// Reloadable down-counting rate divider producing a one-cycle tick every DIV_VALUE+1 run cycles.
// The divider holds its value whenever run is low, so a pause resumes mid-period.
module rate_divider
    import count_ctrl_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int DIV_VALUE = 49_999_999
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    input  logic load,
    output logic tick
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(DIV_VALUE);

    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clock) begin
        if (!resetn || load) begin
            div_q <= RELOAD;
        end else if (run) begin
            div_q <= (div_q == '0) ? RELOAD : div_q - 1'b1;
        end
    end

    // A load (abort or restart) on the same edge suppresses the tick.
    assign tick = resetn && run && !load && (div_q == '0);

endmodule

// File: rtl/count_ctrl.sv
// Start/pause/clear controlled tick counter with optional terminal count.
// Define COUNT_CTRL_DOWN_EN to add the dir input and down-counting mode.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter int DIV_W     = DIV_W_DEFAULT,
    parameter int DIV_VALUE = 49_999_999
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
`ifdef COUNT_CTRL_DOWN_EN
    input  logic             dir,
`endif
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] count_dec;
    logic             start_req;
    logic             div_run;
    logic             div_load;
    logic             div_tick;

    assign start_req = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign div_run   = (state_q == ST_RUN) && !pause;
    assign div_load  = clear || start_req;
    assign count_inc = count_q + 1'b1;
    assign count_dec = count_q - 1'b1;

    rate_divider #(
        .DIV_W     (DIV_W),
        .DIV_VALUE (DIV_VALUE)
    ) u_rate_divider (
        .clock  (clock),
        .resetn (resetn),
        .run    (div_run),
        .load   (div_load),
        .tick   (div_tick)
    );

`ifdef COUNT_CTRL_DOWN_EN
    logic dir_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            dir_q <= 1'b0;
        end else if (!clear && start_req) begin
            dir_q <= dir;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
        end
    end

    always_comb begin
        state_n = state_q;
        count_n = count_q;
        if (clear) begin
            state_n = ST_IDLE;
            count_n = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_n = ST_RUN;
                        count_n = '0;
`ifdef COUNT_CTRL_DOWN_EN
                        if (dir) count_n = limit;
`endif
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_n = ST_PAUSE;
                    end else if (div_tick) begin
`ifdef COUNT_CTRL_DOWN_EN
                        if (dir_q) begin
                            count_n = count_dec;
                            if ((limit != '0) && (count_dec == '0)) state_n = ST_DONE;
                        end else begin
                            count_n = count_inc;
                            if ((limit != '0) && (count_inc == limit)) state_n = ST_DONE;
                        end
`else
                        count_n = count_inc;
                        if ((limit != '0) && (count_inc == limit)) state_n = ST_DONE;
`endif
                    end
                end
                ST_PAUSE: begin
                    if (!pause) state_n = ST_RUN;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

`ifndef COUNT_CTRL_DOWN_EN
    // Decrement path is only consumed by the down-counting build.
    logic unused_dec;
    assign unused_dec = ^count_dec;
`endif

    assign count = count_q;
    assign tick  = div_tick;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done  = (state_q == ST_DONE);
    assign state = state_q;

endmodule
